// File: rtl/prescaler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prescaler_pkg
// Description : Shared state encoding, mode constants and divisor clamp
//               for the programmable prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
package prescaler_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    localparam int DIV_MAX_W = 32;

    // A zero divisor has no meaning; treat it as divide-by-one.
    function automatic logic [DIV_MAX_W-1:0] clamp_div(input logic [DIV_MAX_W-1:0] d);
        return (d == '0) ? DIV_MAX_W'(1) : d;
    endfunction

endpackage : prescaler_pkg
`default_nettype wire

// File: rtl/prescaler_div_shadow.sv
`default_nettype none
// ============================================================================
// Module      : prescaler_div_shadow
// Description : Shadow/pending divisor register; transfers the shadow into
//               the active divisor when the caller signals an apply point.
// Revision    : 1.0 - initial release
// ============================================================================
module prescaler_div_shadow
    import prescaler_pkg::*;
#(
    parameter int WIDTH       = 27,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             apply,
    output logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] div_out
);

    logic [WIDTH-1:0] r_shadow;
    logic             r_pending;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] w_div_in_clamped;

    assign w_div_in_clamped = WIDTH'(clamp_div(DIV_MAX_W'(div_in)));

    // A LOAD in the apply cycle lands after the transfer, so it stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= WIDTH'(DEFAULT_DIV);
            r_pending <= 1'b0;
            r_div     <= WIDTH'(DEFAULT_DIV);
        end else begin
            if (apply && r_pending) begin
                r_div     <= r_shadow;
                r_pending <= 1'b0;
            end
            if (load) begin
                r_shadow  <= w_div_in_clamped;
                r_pending <= 1'b1;
            end
        end
    end

    assign div     = r_div;
    assign div_out = r_div;

endmodule : prescaler_div_shadow
`default_nettype wire

// File: rtl/prog_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : prog_prescaler
// Description : Programmable CE prescaler with continuous/one-shot modes and
//               glitch-free divisor update. Optional SQW output when
//               PRESCALER_SQW_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_prescaler
    import prescaler_pkg::*;
#(
    parameter int WIDTH       = 27,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CE,
    input  logic [WIDTH-1:0] DIV_IN,
    input  logic             LOAD,
    input  logic             ONESHOT,
    input  logic             START,
    input  logic             SYNC,
    output logic             CEO,
    output logic             ACTIVE,
    output logic [WIDTH-1:0] DIV_OUT
`ifdef PRESCALER_SQW_EN
    ,
    output logic             SQW
`endif
);

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nx;
    logic [WIDTH-1:0] w_div;
    logic             w_tc;
    logic             w_apply;

    prescaler_div_shadow #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_div_shadow (
        .clk     (CLK),
        .rst     (CLR),
        .load    (LOAD),
        .div_in  (DIV_IN),
        .apply   (w_apply),
        .div     (w_div),
        .div_out (DIV_OUT)
    );

    // Div is never zero, so Div-1 cannot wrap.
    assign w_tc = (r_count == (w_div - WIDTH'(1)));

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= (ONESHOT == MODE_ONESHOT) ? ST_IDLE : ST_RUN;
            r_count <= '0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_apply    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_count_nx = '0;
                w_apply    = 1'b1;
                if (START || (ONESHOT == MODE_CONT)) begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (SYNC) begin
                    w_count_nx = '0;
                    w_apply    = 1'b1;
                end else if (CE) begin
                    if (w_tc) begin
                        w_count_nx = '0;
                        w_apply    = 1'b1;
                        if (ONESHOT == MODE_ONESHOT) begin
                            w_state_nx = ST_IDLE;
                        end
                    end else begin
                        w_count_nx = r_count + WIDTH'(1);
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_count_nx = '0;
            end
        endcase
    end

    // Combinational so chained prescalers stay cycle-aligned.
    assign CEO    = !CLR && !SYNC && (r_state == ST_RUN) && CE && w_tc;
    assign ACTIVE = (r_state == ST_RUN);

`ifdef PRESCALER_SQW_EN
    logic r_sqw;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_sqw <= 1'b0;
        end else begin
            r_sqw <= (r_state == ST_RUN) && (r_count < (w_div >> 1));
        end
    end

    assign SQW = r_sqw;
`endif

endmodule : prog_prescaler
`default_nettype wire

// File: tb/tb_prog_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_prescaler
// Description : Scoreboard bench for prog_prescaler (WIDTH=27, DEFAULT_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_prescaler;

    localparam int WIDTH = 27;

    typedef struct {
        logic             ceo;
        logic             active;
        logic [WIDTH-1:0] div;
    } exp_t;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             ce = 1'b0;
    logic [WIDTH-1:0] div_in = '0;
    logic             load = 1'b0;
    logic             oneshot = 1'b0;
    logic             start = 1'b0;
    logic             sync = 1'b0;
    logic             ceo;
    logic             active;
    logic [WIDTH-1:0] div_out;
`ifdef PRESCALER_SQW_EN
    logic             sqw;
`endif

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prog_prescaler #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (4)
    ) dut (
        .CLK     (clk),
        .CLR     (clr),
        .CE      (ce),
        .DIV_IN  (div_in),
        .LOAD    (load),
        .ONESHOT (oneshot),
        .START   (start),
        .SYNC    (sync),
        .CEO     (ceo),
        .ACTIVE  (active),
        .DIV_OUT (div_out)
`ifdef PRESCALER_SQW_EN
        ,
        .SQW     (sqw)
`endif
    );

    task automatic do_reset(input logic os);
        clr = 1'b1; ce = 1'b1; load = 1'b0; start = 1'b0; sync = 1'b0;
        div_in = '0; oneshot = os;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; ce = 1'b1; oneshot = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        sb.push_back('{ceo: 1'b0, active: 1'b1, div: WIDTH'(4)});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({ceo, active, div_out} !== {e.ceo, e.active, e.div}) begin
            errors++;
            $display("FAIL reset_cont got ceo=%b act=%b div=%0d exp ceo=%b act=%b div=%0d",
                     ceo, active, div_out, e.ceo, e.active, e.div);
        end
        oneshot = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{ceo: 1'b0, active: 1'b0, div: WIDTH'(4)});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({ceo, active, div_out} !== {e.ceo, e.active, e.div}) begin
            errors++;
            $display("FAIL reset_oneshot got ceo=%b act=%b div=%0d exp ceo=%b act=%b div=%0d",
                     ceo, active, div_out, e.ceo, e.active, e.div);
        end
    endtask

    task automatic test_continuous();
        do_reset(1'b0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            sb.push_back('{ceo: (cyc % 4 == 0), active: 1'b1, div: WIDTH'(4)});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if ({ceo, active, div_out} !== {e.ceo, e.active, e.div}) begin
                errors++;
                $display("FAIL continuous cyc=%0d got ceo=%b act=%b div=%0d exp ceo=%b act=%b div=%0d",
                         cyc, ceo, active, div_out, e.ceo, e.active, e.div);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ce_toggle();
        do_reset(1'b0);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            ce = (cyc % 2 == 1);
            sb.push_back('{ceo: ((cyc + 1) % 8 == 0), active: 1'b1, div: WIDTH'(4)});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if ({ceo, active, div_out} !== {e.ceo, e.active, e.div}) begin
                errors++;
                $display("FAIL ce_toggle cyc=%0d got ceo=%b act=%b div=%0d exp ceo=%b act=%b div=%0d",
                         cyc, ceo, active, div_out, e.ceo, e.active, e.div);
            end
            @(posedge clk); #1;
        end
        ce = 1'b1;
    endtask

    task automatic test_load_midperiod();
        do_reset(1'b0);
        for (int cyc = 1; cyc <= 13; cyc++) begin
            load   = (cyc == 2);
            div_in = WIDTH'(3);
            sb.push_back('{ceo: (cyc == 4) || (cyc > 4 && (cyc - 4) % 3 == 0),
                           active: 1'b1, div: (cyc <= 4) ? WIDTH'(4) : WIDTH'(3)});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if ({ceo, active, div_out} !== {e.ceo, e.active, e.div}) begin
                errors++;
                $display("FAIL load_mid cyc=%0d got ceo=%b act=%b div=%0d exp ceo=%b act=%b div=%0d",
                         cyc, ceo, active, div_out, e.ceo, e.active, e.div);
            end
            @(posedge clk); #1;
        end
        load = 1'b0;
    endtask

    task automatic test_oneshot();
        do_reset(1'b1);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            load   = (cyc == 1);
            div_in = WIDTH'(5);
            start  = (cyc == 3) || (cyc == 6);
            sb.push_back('{ceo: (cyc == 8), active: (cyc >= 4 && cyc <= 8),
                           div: (cyc <= 2) ? WIDTH'(4) : WIDTH'(5)});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if ({ceo, active, div_out} !== {e.ceo, e.active, e.div}) begin
                errors++;
                $display("FAIL oneshot cyc=%0d got ceo=%b act=%b div=%0d exp ceo=%b act=%b div=%0d",
                         cyc, ceo, active, div_out, e.ceo, e.active, e.div);
            end
            @(posedge clk); #1;
        end
        load = 1'b0; start = 1'b0;
    endtask

    task automatic test_sync();
        do_reset(1'b0);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            load   = (cyc == 2);
            div_in = WIDTH'(6);
            sync   = (cyc == 3) || (cyc == 9);
            sb.push_back('{ceo: (cyc == 15), active: 1'b1,
                           div: (cyc <= 3) ? WIDTH'(4) : WIDTH'(6)});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if ({ceo, active, div_out} !== {e.ceo, e.active, e.div}) begin
                errors++;
                $display("FAIL sync cyc=%0d got ceo=%b act=%b div=%0d exp ceo=%b act=%b div=%0d",
                         cyc, ceo, active, div_out, e.ceo, e.active, e.div);
            end
            @(posedge clk); #1;
        end
        load = 1'b0; sync = 1'b0;
    endtask

    task automatic test_div_zero_and_clr();
        do_reset(1'b0);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            load   = (cyc == 1);
            div_in = '0;
            ce     = (cyc != 9);
            clr    = (cyc == 11);
            sb.push_back('{ceo: (cyc == 4) || (cyc >= 5 && cyc <= 10 && cyc != 9),
                           active: 1'b1,
                           div: (cyc <= 4) ? WIDTH'(4) : (cyc <= 11) ? WIDTH'(1) : WIDTH'(4)});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if ({ceo, active, div_out} !== {e.ceo, e.active, e.div}) begin
                errors++;
                $display("FAIL div_zero_clr cyc=%0d got ceo=%b act=%b div=%0d exp ceo=%b act=%b div=%0d",
                         cyc, ceo, active, div_out, e.ceo, e.active, e.div);
            end
            @(posedge clk); #1;
        end
        load = 1'b0; ce = 1'b1; clr = 1'b0;
    endtask

    task automatic test_mode_change();
        do_reset(1'b1);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            oneshot = (cyc >= 3);
            sb.push_back('{ceo: (cyc == 5), active: (cyc >= 2 && cyc <= 5), div: WIDTH'(4)});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if ({ceo, active, div_out} !== {e.ceo, e.active, e.div}) begin
                errors++;
                $display("FAIL mode_change cyc=%0d got ceo=%b act=%b div=%0d exp ceo=%b act=%b div=%0d",
                         cyc, ceo, active, div_out, e.ceo, e.active, e.div);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_continuous();
        test_ce_toggle();
        test_load_midperiod();
        test_oneshot();
        test_sync();
        test_div_zero_and_clr();
        test_mode_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_prog_prescaler
`default_nettype wire
